mem_arbiter: RTL
================

# mem_arbiter

- Shares one line-granular backing memory between the I-cache refill port and the D-cache refill/writeback port of the pipelined core.
- Accepts one request at a time and forwards it to memory.
- Waits for the memory acknowledgement, then returns a one-cycle response to the owning requester.
- Round-robin grant between the two ports prevents starvation; per-port grant counters support cache-performance reporting.

## Interface
- LINE_SIZE, 16, line size in bytes; data buses are LINE_SIZE*8 bits; power of two.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_req_valid  in  1  D-cache request pending.
- d_req_ready  out  1  D request accepted this cycle.
- d_req_addr  in  32  D byte address.
- d_req_write  in  1  1 = line write, 0 = line read.
- d_req_din  in  LINE_SIZE*8  D write line.
- d_resp_valid  out  1  D response pulse.
- d_resp_dout  out  LINE_SIZE*8  D read line.
- i_req_valid, i_req_ready, i_req_addr, i_req_write, i_req_din, i_resp_valid, i_resp_dout: same as the d_* ports, for the I-cache.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  line-aligned address.
- mem_write  out  1  write command.
- mem_din  out  LINE_SIZE*8  write line.
- mem_resp_valid  in  1  memory completion (read data or write ack).
- mem_resp_dout  in  LINE_SIZE*8  read line.
- busy  out  1  state != IDLE.
- d_grant_cnt, i_grant_cnt  out  32  grants issued per port; wrap modulo 2^32.

## Operation
**FSM states:** IDLE, ISSUE, WAIT, RESP.

**IDLE**
- If exactly one *_req_valid is high, that port wins.
- If both are high, the port not equal to last_grant wins; after reset last_grant = I, so D wins the first tie.
- Winner's *_req_ready is high combinationally in this cycle.
- Latch addr (low log2(LINE_SIZE) bits forced to 0), write, din and owner.
- Increment the owner's grant counter.
- Go to ISSUE.

**ISSUE**
- mem_req_valid = 1; mem_addr, mem_write and mem_din come from the latched values.
- Go to WAIT in the cycle mem_req_ready = 1.

**WAIT**
- On mem_resp_valid, latch the data: mem_resp_dout for reads, 0 for writes.
- Go to RESP.

**RESP**
- Owner's *_resp_valid = 1 for exactly one cycle, with the latched data on *_resp_dout.
- No backpressure; requesters must accept.
- last_grant <= owner; go to IDLE.

**Boundary and ordering rules**
- Never more than one transaction outstanding.
- The non-owner's *_resp_valid stays 0.
- mem_resp_valid outside WAIT is ignored.
- Requesters hold valid and request fields stable until ready; the arbiter never deasserts ready once asserted for a request.
- No request is accepted in ISSUE, WAIT or RESP; this gives a one-cycle turnaround after RESP.
- Reset mid-transaction:
  - FSM returns to IDLE and last_grant to I.
  - All outputs drop immediately.
  - A later memory response is ignored in IDLE.

## Timing
- **Reset values:** all *_req_ready, *_resp_valid, mem_req_valid, mem_write and busy = 0; mem_addr, mem_din, *_resp_dout = 0; counters = 0.
- **Handshake cycles:**
  - Cycle T: request accepted.
  - Cycle T+1: mem_req_valid first high.
  - If memory is ready at T+1 and responds L cycles after acceptance, *_resp_valid is high at T+2+L.
- **Minimum issue rate:** back-to-back requests are accepted at intervals of ≥ 4 + L cycles.
- **Output style:** *_req_ready is combinational from state and valids; all other outputs are registered.

## Structure
- **Package mem_arb_pkg:**
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - Port-ID constants: PORT_D = 0, PORT_I = 1.
  - Default LINE_SIZE.
- **Sub-module rr_grant_picker:**
  - Combinational winner select from two valids plus last_grant.
  - Owns the last_grant register (update strobe from RESP, asynchronous reset).

## Test plan
- **Single D read.** d_req_valid with addr 0x104, read; memory ready immediately, responds after L = 3 with 0xA5…A5.
  - mem_addr = 0x100.
  - d_resp_valid pulses once with 0xA5…A5 at T+5.
  - i_resp_valid stays 0.
  - d_grant_cnt = 1.
- **Simultaneous requests after reset.** D read 0x200 and I read 0x300 both valid.
  - D granted first, then I.
  - Grants alternate D, I, D, I over 4 transactions with both held valid.
- **D write then I read.** D write 0x40, data 0x1234…; then I read 0x40.
  - mem_write = 1 for the first transaction.
  - d_resp_dout = 0.
  - The I read is accepted only after d_resp_valid plus one idle cycle.
- **Memory backpressure.** mem_req_ready held 0 for 5 cycles.
  - mem_req_valid and mem_addr stay stable.
  - No *_req_ready is asserted to the waiting I port.
- **Reset during WAIT.** reset low while in WAIT, then the late mem_resp_valid arrives.
  - All outputs are 0 during reset.
  - No *_resp_valid after release.
  - Counters = 0.
  - The next tie grants D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port line memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;
  localparam int   DEF_LINE_SIZE = 16;

  function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_size);
    return addr & ~(32'(line_size) - 32'd1);
  endfunction
endpackage

// File: rtl/rr_grant_picker.sv
// Two-way round-robin winner select; owns the last-grant history bit.
module rr_grant_picker import mem_arb_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic d_valid,
  input  logic i_valid,
  input  logic upd,
  input  logic upd_port,
  output logic gnt_valid,
  output logic gnt_port
);
  logic last_q, last_d;

  always_comb begin
    last_d    = upd ? upd_port : last_q;
    gnt_valid = d_valid | i_valid;
    if (d_valid && i_valid) gnt_port = ~last_q;
    else                    gnt_port = i_valid ? PORT_I : PORT_D;
  end

  // I counts as last winner out of reset so the first tie goes to D.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= PORT_I;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line refills onto one backing memory,
// one transaction in flight, round-robin on ties.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int LINE_SIZE = DEF_LINE_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [31:0]            d_req_addr,
  input  logic                   d_req_write,
  input  logic [LINE_SIZE*8-1:0] d_req_din,
  output logic                   d_resp_valid,
  output logic [LINE_SIZE*8-1:0] d_resp_dout,
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [31:0]            i_req_addr,
  input  logic                   i_req_write,
  input  logic [LINE_SIZE*8-1:0] i_req_din,
  output logic                   i_resp_valid,
  output logic [LINE_SIZE*8-1:0] i_resp_dout,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_addr,
  output logic                   mem_write,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_resp_valid,
  input  logic [LINE_SIZE*8-1:0] mem_resp_dout,
  output logic                   busy,
  output logic [31:0]            d_grant_cnt,
  output logic [31:0]            i_grant_cnt
);
  localparam int LW = LINE_SIZE * 8;

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d, write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [LW-1:0] din_q, din_d, rdata_q, rdata_d;
  logic          mreq_q, mreq_d, busy_q, busy_d, tat_q, tat_d;
  logic          d_rv_q, d_rv_d, i_rv_q, i_rv_d;
  logic [31:0]   d_cnt_q, d_cnt_d, i_cnt_q, i_cnt_d;
  logic          gnt_valid, gnt_port, accept, upd;

  rr_grant_picker u_pick (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_req_valid),
    .i_valid   (i_req_valid),
    .upd       (upd),
    .upd_port  (owner_q),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  // tat_q blocks acceptance for the single IDLE cycle right after RESP.
  assign accept      = reset && (state_q == IDLE) && !tat_q && gnt_valid;
  assign d_req_ready = accept && (gnt_port == PORT_D);
  assign i_req_ready = accept && (gnt_port == PORT_I);
  assign upd         = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    mreq_d  = mreq_q;
    busy_d  = busy_q;
    tat_d   = 1'b0;
    d_rv_d  = 1'b0;
    i_rv_d  = 1'b0;
    d_cnt_d = d_cnt_q;
    i_cnt_d = i_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        owner_d = gnt_port;
        addr_d  = line_align((gnt_port == PORT_I) ? i_req_addr : d_req_addr, LINE_SIZE);
        write_d = (gnt_port == PORT_I) ? i_req_write : d_req_write;
        din_d   = (gnt_port == PORT_I) ? i_req_din : d_req_din;
        if (gnt_port == PORT_I) i_cnt_d = i_cnt_q + 32'd1;
        else                    d_cnt_d = d_cnt_q + 32'd1;
        mreq_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (mem_req_ready) begin
        mreq_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: if (mem_resp_valid) begin
        rdata_d = write_q ? '0 : mem_resp_dout;
        d_rv_d  = (owner_q == PORT_D);
        i_rv_d  = (owner_q == PORT_I);
        state_d = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        tat_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= PORT_D;
      write_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      mreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      tat_q   <= 1'b0;
      d_rv_q  <= 1'b0;
      i_rv_q  <= 1'b0;
      d_cnt_q <= '0;
      i_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      mreq_q  <= mreq_d;
      busy_q  <= busy_d;
      tat_q   <= tat_d;
      d_rv_q  <= d_rv_d;
      i_rv_q  <= i_rv_d;
      d_cnt_q <= d_cnt_d;
      i_cnt_q <= i_cnt_d;
    end
  end

  assign mem_req_valid = mreq_q;
  assign mem_addr      = addr_q;
  assign mem_write     = write_q;
  assign mem_din       = din_q;
  assign d_resp_valid  = d_rv_q;
  assign i_resp_valid  = i_rv_q;
  assign d_resp_dout   = rdata_q;
  assign i_resp_dout   = rdata_q;
  assign busy          = busy_q;
  assign d_grant_cnt   = d_cnt_q;
  assign i_grant_cnt   = i_cnt_q;
endmodule
